// File: rtl/display_ctrl_pkg.sv
// Shared encodings for the display refresh controller: FSM states,
// set-mode field selection and the per-field blank mask layout.
package display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_WAIT_FALL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE    = 2'd0,
        MODE_HOURS   = 2'd1,
        MODE_MINUTES = 2'd2,
        MODE_SECONDS = 2'd3
    } set_mode_t;

    localparam int BLANK_HOURS_BIT   = 2;
    localparam int BLANK_MINUTES_BIT = 1;
    localparam int BLANK_SECONDS_BIT = 0;

    // One-hot blank for the field being set, only while the blink phase is on.
    function automatic logic [2:0] blank_mask(input logic [1:0] mode, input logic phase);
        logic [2:0] mask;
        mask = '0;
        if (phase) begin
            case (set_mode_t'(mode))
                MODE_HOURS:   mask[BLANK_HOURS_BIT]   = 1'b1;
                MODE_MINUTES: mask[BLANK_MINUTES_BIT] = 1'b1;
                MODE_SECONDS: mask[BLANK_SECONDS_BIT] = 1'b1;
                default:      mask = '0;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/brightness_pwm.sv
// Frame-based brightness PWM: a 4-bit frame counter stepped once per
// completed frame, compared against the requested duty (frames per 16).
module brightness_pwm (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_advance,
    input  logic [3:0] i_brightness,
    output logic       o_frame_en
);

    logic [3:0] frame_cnt;

    // Frame counter: steps on each completed frame, wrapping 15 -> 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_cnt <= '0;
        end else if (i_advance) begin
            frame_cnt <= frame_cnt + 4'd1;
        end
    end

    // Full brightness never blanks; otherwise the first i_brightness frames are lit.
    assign o_frame_en = (i_brightness == 4'hF) || (frame_cnt < i_brightness);

endmodule

// File: rtl/display_refresh_ctrl.sv
// Display refresh controller: coalesces refresh/time/blink/mode requests into
// a single pending flag, issues one start strobe per frame to the serial
// datapath and tracks its busy handshake with a rise watchdog.
module display_refresh_ctrl
    import display_ctrl_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_refresh_stb,
    input  logic       i_time_stb,
    input  logic       i_blink_stb,
    input  logic [1:0] i_set_mode,
    input  logic [3:0] i_brightness,
    input  logic       i_busy,
    output logic       o_start_stb,
    output logic       o_display_en,
    output logic [2:0] o_field_blank,
    output logic       o_timeout
);

    localparam int                TCNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(BUSY_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              pending;
    logic              blink_phase;
    logic [1:0]        set_mode_q;
    logic [TCNT_W-1:0] tcnt;
    logic              request;
    logic              busy_fall;
    logic              timeout_hit;
    logic              tcnt_expired;
    logic              frame_en;

    assign request      = i_refresh_stb | i_time_stb | i_blink_stb | (i_set_mode != set_mode_q);
    assign tcnt_expired = (tcnt == TCNT_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Next-state decode, start strobe and handshake events.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_nxt   = state;
        o_start_stb = 1'b0;
        busy_fall   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    o_start_stb = 1'b1;
                    state_nxt   = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (i_busy) begin
                    state_nxt = ST_WAIT_FALL;
                end else if (tcnt_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_FALL: begin
                if (!i_busy) begin
                    busy_fall = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pending flag: a new request wins over the start consuming the old one,
    // so a request landing in the start cycle still earns its own frame.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending <= 1'b0;
        end else if (request) begin
            pending <= 1'b1;
        end else if (o_start_stb) begin
            pending <= 1'b0;
        end
    end

    // Request-source history: previous set mode (for change detect) and blink phase.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            set_mode_q  <= 2'd0;
            blink_phase <= 1'b0;
        end else begin
            set_mode_q <= i_set_mode;
            if (i_blink_stb) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    // Busy-rise watchdog: counts only while waiting for busy, cleared otherwise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tcnt <= '0;
        end else if (state == ST_WAIT_RISE && !i_busy && !tcnt_expired) begin
            tcnt <= tcnt + TCNT_W'(1);
        end else begin
            tcnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_timeout <= 1'b0;
        end else if (timeout_hit) begin
            o_timeout <= 1'b1;
        end
    end

    // Frame attributes captured by the start strobe and held until the next start.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_display_en  <= 1'b0;
            o_field_blank <= 3'b000;
        end else if (o_start_stb) begin
            o_display_en  <= frame_en;
            o_field_blank <= blank_mask(i_set_mode, blink_phase);
        end
    end

    brightness_pwm u_pwm (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_advance    (busy_fall),
        .i_brightness (i_brightness),
        .o_frame_en   (frame_en)
    );

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Directed bench for display_refresh_ctrl: a vector table of complete frames
// (brightness / set mode / blink) plus hand-written handshake corner cases.
module tb_display_refresh_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refresh_stb;
    logic       time_stb;
    logic       blink_stb;
    logic [1:0] set_mode;
    logic [3:0] brightness;
    logic       busy;
    logic       start_stb;
    logic       display_en;
    logic [2:0] field_blank;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int extra;

    typedef struct {
        logic [3:0] br;
        logic [1:0] mode;
        logic       blink;
        logic       exp_en;
        logic [2:0] exp_blank;
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    display_refresh_ctrl #(.BUSY_TIMEOUT(64)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_refresh_stb (refresh_stb),
        .i_time_stb    (time_stb),
        .i_blink_stb   (blink_stb),
        .i_set_mode    (set_mode),
        .i_brightness  (brightness),
        .i_busy        (busy),
        .o_start_stb   (start_stb),
        .o_display_en  (display_en),
        .o_field_blank (field_blank),
        .o_timeout     (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_strobes();
        refresh_stb = 1'b0;
        time_stb    = 1'b0;
        blink_stb   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        busy       = 1'b0;
        set_mode   = 2'd0;
        brightness = 4'd0;
        clear_strobes();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at the negedge of the start cycle: raises busy, holds it for
    // 'hold' cycles while counting any further starts, then drops it.
    task automatic finish_transfer(input int hold, output int n_extra);
        n_extra = 0;
        busy    = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (start_stb) n_extra++;
        end
        busy = 1'b0;
    endtask

    task automatic count_starts(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (start_stb) n++;
        end
    endtask

    initial begin
        // frame index = vector index mod 16; blink phase tracked by hand
        vecs[0]  = '{4'd4,  2'd0, 1'b0, 1'b1, 3'b000};
        vecs[1]  = '{4'd4,  2'd2, 1'b1, 1'b1, 3'b010};
        vecs[2]  = '{4'd4,  2'd2, 1'b1, 1'b1, 3'b000};
        vecs[3]  = '{4'd4,  2'd1, 1'b1, 1'b1, 3'b100};
        vecs[4]  = '{4'd4,  2'd3, 1'b0, 1'b0, 3'b001};
        vecs[5]  = '{4'd15, 2'd3, 1'b1, 1'b1, 3'b000};
        vecs[6]  = '{4'd0,  2'd0, 1'b1, 1'b0, 3'b000};
        vecs[7]  = '{4'd7,  2'd1, 1'b0, 1'b0, 3'b100};
        vecs[8]  = '{4'd9,  2'd1, 1'b0, 1'b1, 3'b100};
        vecs[9]  = '{4'd0,  2'd2, 1'b1, 1'b0, 3'b000};
        vecs[10] = '{4'd15, 2'd2, 1'b1, 1'b1, 3'b010};
        vecs[11] = '{4'd12, 2'd0, 1'b0, 1'b1, 3'b000};
        vecs[12] = '{4'd12, 2'd0, 1'b1, 1'b0, 3'b000};
        vecs[13] = '{4'd14, 2'd3, 1'b1, 1'b1, 3'b001};
        vecs[14] = '{4'd14, 2'd3, 1'b0, 1'b0, 3'b001};
        vecs[15] = '{4'd15, 2'd3, 1'b1, 1'b1, 3'b000};
        vecs[16] = '{4'd1,  2'd1, 1'b1, 1'b1, 3'b100};
        vecs[17] = '{4'd1,  2'd0, 1'b0, 1'b0, 3'b000};

        // Reset values while reset is held.
        rst_n      = 1'b0;
        busy       = 1'b0;
        set_mode   = 2'd0;
        brightness = 4'd0;
        clear_strobes();
        #1;
        check("reset start_stb", start_stb, 0);
        check("reset display_en", display_en, 0);
        check("reset field_blank", field_blank, 0);
        check("reset timeout", timeout, 0);
        apply_reset();
        check("post-reset no start", start_stb, 0);

        // Table: one complete frame per vector.
        for (int i = 0; i < 18; i++) begin
            brightness  = vecs[i].br;
            set_mode    = vecs[i].mode;
            blink_stb   = vecs[i].blink;
            refresh_stb = 1'b1;
            @(negedge clk);
            clear_strobes();
            check($sformatf("vec%0d start latency", i), start_stb, 1);
            finish_transfer(4, extra);
            check($sformatf("vec%0d extra starts", i), extra, 0);
            @(negedge clk);
            check($sformatf("vec%0d display_en", i), display_en, vecs[i].exp_en);
            check($sformatf("vec%0d field_blank", i), field_blank, vecs[i].exp_blank);
        end

        // Single request: one start one cycle later, none after a long transfer.
        apply_reset();
        repeat (6) @(negedge clk);
        refresh_stb = 1'b1;
        @(negedge clk);
        clear_strobes();
        check("single start cycle", start_stb, 1);
        finish_transfer(48, extra);
        check("single no repeat start", extra, 0);
        count_starts(20, extra);
        check("single idle afterwards", extra, 0);
        refresh_stb = 1'b1;
        @(negedge clk);
        clear_strobes();
        check("single back in idle", start_stb, 1);
        finish_transfer(3, extra);
        @(negedge clk);

        // Coalescing: three time strobes during WAIT_FALL, last on the fall cycle.
        refresh_stb = 1'b1;
        @(negedge clk);
        clear_strobes();
        check("coalesce first start", start_stb, 1);
        busy  = 1'b1;
        extra = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (start_stb) extra++;
            time_stb = (i == 4 || i == 7);
        end
        check("coalesce no start while busy", extra, 0);
        busy     = 1'b0;
        time_stb = 1'b1;
        @(negedge clk);
        time_stb = 1'b0;
        check("coalesce start after fall", start_stb, 1);
        finish_transfer(3, extra);
        check("coalesce single start", extra, 0);
        count_starts(20, extra);
        check("coalesce nothing left pending", extra, 0);
        check("coalesce no timeout", timeout, 0);

        // Busy never rises: timeout after 64 waiting cycles, then recovery.
        refresh_stb = 1'b1;
        @(negedge clk);
        clear_strobes();
        check("timeout start", start_stb, 1);
        extra = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (start_stb) extra++;
        end
        check("timeout not yet at 64", timeout, 0);
        @(negedge clk);
        check("timeout set at 65", timeout, 1);
        check("timeout no start while waiting", extra, 0);
        refresh_stb = 1'b1;
        @(negedge clk);
        clear_strobes();
        check("timeout restart", start_stb, 1);
        finish_transfer(3, extra);
        @(negedge clk);
        check("timeout sticky", timeout, 1);

        // Reset during WAIT_FALL with outputs non-zero.
        brightness  = 4'd15;
        set_mode    = 2'd3;
        blink_stb   = 1'b1;
        refresh_stb = 1'b1;
        @(negedge clk);
        clear_strobes();
        check("midreset start", start_stb, 1);
        busy = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset en before", display_en, 1);
        check("midreset blank before", field_blank, 3'b001);
        rst_n    = 1'b0;
        set_mode = 2'd0;
        #1;
        check("midreset start async", start_stb, 0);
        check("midreset en async", display_en, 0);
        check("midreset blank async", field_blank, 0);
        check("midreset timeout async", timeout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_starts(20, extra);
        check("midreset no start after release", extra, 0);
        busy = 1'b0;
        count_starts(5, extra);
        check("midreset still idle", extra, 0);
        set_mode = 2'd2;
        @(negedge clk);
        check("mode change request start", start_stb, 1);
        finish_transfer(3, extra);
        @(negedge clk);
        check("mode change blank phase off", field_blank, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
